// File: rtl/alu_pipe_pkg.sv
// Shared constants for the ALU output pipeline.
package alu_pipe_pkg;
    localparam int ALU_W              = 32;
    localparam int ALU_PIPE_MAX_DEPTH = 8;
    localparam int ALU_STALL_CNT_W    = 16;
endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/data register slice of the ALU output pipeline.
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign ready = !valid || down_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (ready) begin
                valid <= up_valid;
            end
            // data only moves with a real result, keeping the datapath quiet on bubbles
            if (!flush && ready && up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/alu_out_pipe.sv
// DEPTH-stage elastic pipe for ALU results with flush and occupancy count.
// Optional stall-cycle counter enabled by ALU_OUT_PIPE_STALL_CNT_EN.
module alu_out_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNTW-1:0]  occupancy
`ifdef ALU_OUT_PIPE_STALL_CNT_EN
    ,
    output logic [ALU_STALL_CNT_W-1:0] stall_cycles
`endif
);

    if (DEPTH < 1 || DEPTH > ALU_PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("alu_out_pipe: DEPTH must be within 1..%0d", ALU_PIPE_MAX_DEPTH);
    end

    logic             v   [DEPTH];
    logic [WIDTH-1:0] d   [DEPTH];
    logic             rdy [DEPTH];
    logic             push;
    logic             pop;

    assign in_ready  = rdy[0] && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign pop       = out_valid && out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             dst_ready;

        if (k == 0) begin : g_head_in
            assign src_valid = push;
            assign src_data  = in_data;
        end else begin : g_chain_in
            assign src_valid = v[k-1];
            assign src_data  = d[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail_out
            assign dst_ready = out_ready;
        end else begin : g_chain_out
            assign dst_ready = rdy[k+1];
        end

        alu_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush      (flush),
            .up_valid   (src_valid),
            .up_data    (src_data),
            .down_ready (dst_ready),
            .ready      (rdy[k]),
            .valid      (v[k]),
            .data       (d[k])
        );
    end

    // Tracked incrementally so it lands on the same edge as the valid bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (push && !pop) begin
            occupancy <= occupancy + CNTW'(1);
        end else if (pop && !push) begin
            occupancy <= occupancy - CNTW'(1);
        end
    end

`ifdef ALU_OUT_PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (flush) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_out_pipe.sv
// Self-checking bench for alu_out_pipe against a slot-position reference model.
module tb_alu_out_pipe;
    import alu_pipe_pkg::*;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] occupancy;
`ifdef ALU_OUT_PIPE_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    alu_out_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef ALU_OUT_PIPE_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: held results oldest-first, each with the slot index it sits in.
    logic [W-1:0] m_data [$];
    int           m_pos  [$];
    bit           mv     [ALU_PIPE_MAX_DEPTH];
    int           m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An item advances when the slot ahead is free now or its occupant leaves this edge.
    task automatic m_moves();
        for (int i = 0; i < m_pos.size(); i++) begin
            if (i == 0) mv[i] = (m_pos[0] < D - 1) || out_ready;
            else        mv[i] = (m_pos[i-1] != m_pos[i] + 1) || mv[i-1];
        end
    endtask

    function automatic bit m_in_ready();
        int n = m_pos.size();
        return !flush && (n == 0 || m_pos[n-1] != 0 || mv[n-1]);
    endfunction

    function automatic bit m_out_valid();
        return (m_pos.size() > 0) && (m_pos[0] == D - 1);
    endfunction

    task automatic check_now(input string tag);
        m_moves();
        chk({tag, ".in_ready"},  32'(in_ready),  32'(m_in_ready()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_out_valid()));
        if (m_out_valid()) chk({tag, ".out_data"}, out_data, m_data[0]);
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(m_pos.size()));
`ifdef ALU_OUT_PIPE_STALL_CNT_EN
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
`endif
    endtask

    task automatic m_edge();
        bit ir, ov, pop;
        m_moves();
        ir  = m_in_ready();
        ov  = m_out_valid();
        pop = ov && out_ready;
        if (flush) m_stall = 0;
        else if (ov && !out_ready && m_stall < 65535) m_stall++;
        for (int i = 0; i < m_pos.size(); i++) begin
            if (!(i == 0 && pop) && mv[i]) m_pos[i]++;
        end
        if (pop) begin
            void'(m_data.pop_front());
            void'(m_pos.pop_front());
        end
        if (flush) begin
            m_data.delete();
            m_pos.delete();
        end else if (in_valid && ir) begin
            m_data.push_back(in_data);
            m_pos.push_back(0);
        end
    endtask

    task automatic cyc(input bit iv, input logic [31:0] id, input bit ordy, input bit fl,
                       input string tag);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_now(tag);
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b1;
        flush     = 1'b0;

        // reset held with a live input
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("reset.out_valid", 32'(out_valid), 32'd0);
            chk("reset.out_data",  out_data,       32'd0);
            chk("reset.occupancy", 32'(occupancy), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // streaming 1..5
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_data = i; out_ready = 1'b1; flush = 1'b0;
            #1;
            chk("stream.in_ready", 32'(in_ready), 32'd1);
            cyc(1'b1, i, 1'b1, 1'b0, "stream");
        end
        for (int i = 0; i < D + 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "stream_drain");

        // back-pressure A, B accepted, C held
        cyc(1'b1, 32'hA, 1'b0, 1'b0, "bp");
        cyc(1'b1, 32'hB, 1'b0, 1'b0, "bp");
        in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b0;
        #1;
        chk("bp.full_in_ready",  32'(in_ready),  32'd0);
        chk("bp.full_occupancy", 32'(occupancy), 32'd2);
        chk("bp.head_data",      out_data,       32'hA);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, "bp_hold");
        cyc(1'b1, 32'hC, 1'b0, 1'b0, "bp_hold");
        cyc(1'b1, 32'hC, 1'b1, 1'b0, "bp_release");
        for (int i = 0; i < D + 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain");

        // full with simultaneous push and pop
        cyc(1'b1, 32'h10, 1'b0, 1'b0, "pp_fill");
        cyc(1'b1, 32'h11, 1'b0, 1'b0, "pp_fill");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h12 + i; out_ready = 1'b1;
            #1;
            chk("pp.in_ready",  32'(in_ready),  32'd1);
            chk("pp.occupancy", 32'(occupancy), 32'd2);
            cyc(1'b1, 32'h12 + i, 1'b1, 1'b0, "pp");
        end
        for (int i = 0; i < D + 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "pp_drain");

        // flush with a competing input
        cyc(1'b1, 32'h20, 1'b0, 1'b0, "fl_fill");
        cyc(1'b1, 32'h21, 1'b0, 1'b0, "fl_fill");
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, 32'h77, 1'b0, 1'b1, "flush");
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush.occupancy", 32'(occupancy), 32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < D + 2; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, "flush_after");
            chk("flush.no_77", 32'(out_valid), 32'd0);
        end

        // output stall counting
        cyc(1'b1, 32'h30, 1'b0, 1'b0, "stall_fill");
        for (int i = 0; i < D - 1 + 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, "stall");
`ifdef ALU_OUT_PIPE_STALL_CNT_EN
        chk("stall.count5", 32'(stall_cycles), 32'd5);
`endif
        cyc(1'b0, 32'h0, 1'b0, 1'b1, "stall_flush");
`ifdef ALU_OUT_PIPE_STALL_CNT_EN
        chk("stall.cleared", 32'(stall_cycles), 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 24) == 0), "rand");
        end

        // asynchronous reset mid-transfer
        cyc(1'b1, 32'h55, 1'b0, 1'b0, "ar_fill");
        cyc(1'b1, 32'h56, 1'b0, 1'b0, "ar_fill");
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset.out_valid", 32'(out_valid), 32'd0);
        chk("areset.out_data",  out_data,       32'd0);
        chk("areset.occupancy", 32'(occupancy), 32'd0);
        m_data.delete();
        m_pos.delete();
        m_stall = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h60 + i, 1'($urandom_range(0, 1)), 1'b0, "ar_after");
        for (int i = 0; i < D + 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "ar_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
